control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter MAX_SHIFTS, default 8, SHALL set the shift-count limit for the watchdog.
REQ-002 clk  input  1  SHALL be the rising-edge clock; it is the only clock.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 start  input  1  SHALL be the level request to classify the N value presented to the datapath.
REQ-005 N_equal_0  input  1  SHALL be the datapath status "shift register == 0".
REQ-006 N0_equal_0  input  1  SHALL be the datapath status "shift register bit 0 == 0".
REQ-007 Count_equal_4  input  1  SHALL be the datapath status "ones counter == 4".
REQ-008 NMUX, NLoad  output  1 each  SHALL be the shift-register controls (NMUX=1 selects load N; NMUX=0 selects shift right).
REQ-009 CountMUX, CountLoad  output  1 each  SHALL be the counter controls (CountMUX=1 selects clear; CountMUX=0 selects increment).
REQ-010 OutputMUX, OE  output  1 each  SHALL be the result value and the result enable.
REQ-011 busy  output  1  SHALL be high in every state except IDLE and DONE.
REQ-012 done  output  1  SHALL be high only in DONE.
REQ-013 err  output  1  SHALL be high only in DONE, and only when the watchdog terminated the run.

Function
REQ-014 The block SHALL be a Moore FSM; every output SHALL decode from registered state, result flag and error flag only.
REQ-015 The states SHALL be IDLE, INIT, TEST, INC, SHIFT and DONE.
REQ-016 IDLE: all outputs 0; start=1 -> INIT.
REQ-017 IDLE: start=0 -> stay in IDLE.
REQ-018 INIT: NMUX=1, NLoad=1, CountMUX=1, CountLoad=1; clear the 4-bit shift counter, result and err; -> TEST.
REQ-019 TEST: all datapath controls 0.
REQ-020 TEST transitions SHALL be evaluated in this order:
  - N_equal_0=1 -> DONE, with result=Count_equal_4.
  - shift counter==MAX_SHIFTS -> DONE, with err=1 and result=0 (watchdog).
  - N0_equal_0=0 and Count_equal_4=1 -> DONE, with result=0 (early reject: a fifth one has been found).
  - N0_equal_0=0 -> INC.
  - otherwise -> SHIFT.
REQ-021 INC: CountLoad=1, CountMUX=0; -> SHIFT.
REQ-022 SHIFT: NLoad=1, NMUX=0; increment the shift counter (saturating at 15); -> TEST.
REQ-023 DONE: OE=1 and OutputMUX=result, held until start=0 is sampled.
REQ-024 DONE: start=0 -> IDLE; start held high SHALL NOT retrigger a run.
REQ-025 start SHALL be ignored in INIT, TEST, INC and SHIFT.
REQ-026 Latency from the edge that samples start in IDLE to the edge entering DONE SHALL be 2 + 3k + 2z cycles (k = ones processed, z = zeros below the highest processed one).
REQ-027 Reset SHALL take priority over every transition, including mid-run and in DONE.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE and clear the shift counter, result and err.
REQ-029 After reset, every output SHALL read 0 (NMUX, NLoad, CountMUX, CountLoad, OutputMUX, OE, busy, done, err).
REQ-030 Reset SHALL NOT depend on start or on any status input.

Verification
REQ-031 N=0x0F with a connected datapath, start pulse -> DONE at edge 14; OE=1, OutputMUX=1, err=0.
REQ-032 N=0x00, start -> DONE at edge 2; OutputMUX=0, err=0.
REQ-033 N=0x1F, start -> early reject at edge 14; OutputMUX=0, err=0; NLoad never asserted after the fourth SHIFT.
REQ-034 N_equal_0 stuck 0 and N0_equal_0 stuck 1, start -> DONE at edge 18; err=1, OutputMUX=0; exactly 8 SHIFT cycles.
REQ-035 N=0xF0, rst=1 during the third TEST -> next edge IDLE with all outputs 0; a new start gives a full run with result 1.
REQ-036 start held high through DONE for 5 cycles -> remains in DONE with no second INIT; start=0 -> IDLE on the next edge.

Source files
------------

// File: rtl/control_unit_if.sv
// Handshake and datapath control/status bundle between control_unit and its
// shift/count datapath plus requester.
interface control_unit_if;
    logic start;
    logic N_equal_0;
    logic N0_equal_0;
    logic Count_equal_4;
    logic NMUX;
    logic NLoad;
    logic CountMUX;
    logic CountLoad;
    logic OutputMUX;
    logic OE;
    logic busy;
    logic done;
    logic err;

    // Control unit side.
    modport slave (
        input  start, N_equal_0, N0_equal_0, Count_equal_4,
        output NMUX, NLoad, CountMUX, CountLoad, OutputMUX, OE, busy, done, err
    );

    // Requester / datapath side.
    modport master (
        output start, N_equal_0, N0_equal_0, Count_equal_4,
        input  NMUX, NLoad, CountMUX, CountLoad, OutputMUX, OE, busy, done, err
    );
endinterface

// File: rtl/control_unit.sv
// Moore FSM classifying N as "exactly four ones" by walking a right-shifting
// datapath; a shift-count watchdog bounds runs with faulty status inputs.
module control_unit #(
    parameter int unsigned MAX_SHIFTS = 8
) (
    input  logic           clk,
    input  logic           rst,
    control_unit_if.slave  cu
);
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        TEST,
        INC,
        SHIFT,
        DONE
    } state_e;

    localparam logic [3:0] SHIFT_LIMIT = 4'(MAX_SHIFTS);

    state_e     state_q, state_d;
    logic [3:0] shift_cnt_q, shift_cnt_d;
    logic       result_q, result_d;
    logic       err_q, err_d;

    logic nmux, nload, countmux, countload, outputmux, oe, busy, done, err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_cnt_q <= '0;
            result_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        result_d    = result_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (cu.start) state_d = INIT;
            end
            INIT: begin
                shift_cnt_d = '0;
                result_d    = 1'b0;
                err_d       = 1'b0;
                state_d     = TEST;
            end
            TEST: begin
                // Zero N wins over the watchdog so a full-width word still classifies.
                if (cu.N_equal_0) begin
                    result_d = cu.Count_equal_4;
                    state_d  = DONE;
                end else if (shift_cnt_q == SHIFT_LIMIT) begin
                    result_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else if (!cu.N0_equal_0 && cu.Count_equal_4) begin
                    result_d = 1'b0;
                    state_d  = DONE;
                end else if (!cu.N0_equal_0) begin
                    state_d = INC;
                end else begin
                    state_d = SHIFT;
                end
            end
            INC: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (shift_cnt_q != 4'hF) shift_cnt_d = shift_cnt_q + 4'd1;
                state_d = TEST;
            end
            DONE: begin
                if (!cu.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nmux      = 1'b0;
        nload     = 1'b0;
        countmux  = 1'b0;
        countload = 1'b0;
        outputmux = 1'b0;
        oe        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            IDLE: ;
            INIT: begin
                nmux      = 1'b1;
                nload     = 1'b1;
                countmux  = 1'b1;
                countload = 1'b1;
                busy      = 1'b1;
            end
            TEST: begin
                busy = 1'b1;
            end
            INC: begin
                countload = 1'b1;
                busy      = 1'b1;
            end
            SHIFT: begin
                nload = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                oe        = 1'b1;
                outputmux = result_q;
                done      = 1'b1;
                err       = err_q;
            end
            default: ;
        endcase
    end

    assign cu.NMUX      = nmux;
    assign cu.NLoad     = nload;
    assign cu.CountMUX  = countmux;
    assign cu.CountLoad = countload;
    assign cu.OutputMUX = outputmux;
    assign cu.OE        = oe;
    assign cu.busy      = busy;
    assign cu.done      = done;
    assign cu.err       = err;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit driving a behavioural shift/count datapath.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_unit_if cu_if ();

    control_unit #(.MAX_SHIFTS(8)) dut (
        .clk (clk),
        .rst (rst),
        .cu  (cu_if.slave)
    );

    // Behavioural datapath: 8-bit shift register and ones counter.
    logic [7:0] n_reg = '0;
    logic [7:0] n_in  = '0;
    logic [2:0] cnt_reg = '0;
    logic       stuck = 1'b0;

    always @(posedge clk) begin
        if (cu_if.NLoad) n_reg <= cu_if.NMUX ? n_in : (n_reg >> 1);
        if (cu_if.CountLoad) cnt_reg <= cu_if.CountMUX ? 3'd0 : cnt_reg + 3'd1;
    end

    assign cu_if.N_equal_0     = stuck ? 1'b0 : (n_reg == 8'd0);
    assign cu_if.N0_equal_0    = stuck ? 1'b1 : ~n_reg[0];
    assign cu_if.Count_equal_4 = (cnt_reg == 3'd4);

    int checks = 0;
    int passed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {NMUX,NLoad,CountMUX,CountLoad,OutputMUX,OE,busy,done,err}
    function automatic logic [31:0] outs();
        return {23'd0, cu_if.NMUX, cu_if.NLoad, cu_if.CountMUX, cu_if.CountLoad,
                cu_if.OutputMUX, cu_if.OE, cu_if.busy, cu_if.done, cu_if.err};
    endfunction

    localparam logic [31:0] O_ZERO   = 32'b000000000;
    localparam logic [31:0] O_INIT   = 32'b111100100;
    localparam logic [31:0] O_DONE0  = 32'b000001010;
    localparam logic [31:0] O_DONE1  = 32'b000011010;
    localparam logic [31:0] O_DONEER = 32'b000001011;

    // Starts a run from IDLE; edges counts edges after the one that sampled start.
    task automatic run(input logic [7:0] n, input bit hold,
                       output int edges, output int shifts);
        n_in = n;
        cu_if.start = 1'b1;
        tick();
        if (!hold) cu_if.start = 1'b0;
        check("init_outputs", outs(), O_INIT);
        edges  = 0;
        shifts = 0;
        while (!cu_if.done && edges < 60) begin
            tick();
            edges++;
            if (cu_if.NLoad && !cu_if.NMUX) shifts++;
        end
    endtask

    int edges, shifts, tests;

    initial begin
        cu_if.start = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", outs(), O_ZERO);
        rst = 1'b0;
        tick();
        check("idle_no_start", outs(), O_ZERO);

        // Four ones: result 1.
        run(8'h0F, 1'b0, edges, shifts);
        check("0F_latency", 32'(edges), 32'd14);
        check("0F_done_outs", outs(), O_DONE1);
        check("0F_shifts", 32'(shifts), 32'd4);
        tick();
        check("0F_back_idle", outs(), O_ZERO);

        // Zero N: immediate DONE, result 0.
        run(8'h00, 1'b0, edges, shifts);
        check("00_latency", 32'(edges), 32'd2);
        check("00_done_outs", outs(), O_DONE0);
        tick();

        // Five ones: early reject on the fifth.
        run(8'h1F, 1'b0, edges, shifts);
        check("1F_latency", 32'(edges), 32'd14);
        check("1F_done_outs", outs(), O_DONE0);
        check("1F_shifts", 32'(shifts), 32'd4);
        tick();

        // Three ones with gaps: 2 + 3*3 + 2*2 = 15, result 0.
        run(8'h15, 1'b0, edges, shifts);
        check("15_latency", 32'(edges), 32'd15);
        check("15_done_outs", outs(), O_DONE0);
        tick();

        // Broken datapath: watchdog after 8 shifts.
        stuck = 1'b1;
        run(8'h00, 1'b0, edges, shifts);
        check("wd_latency", 32'(edges), 32'd18);
        check("wd_done_outs", outs(), O_DONEER);
        check("wd_shifts", 32'(shifts), 32'd8);
        stuck = 1'b0;
        tick();
        check("wd_back_idle", outs(), O_ZERO);

        // Reset during the third TEST of an 0xF0 run.
        n_in = 8'hF0;
        cu_if.start = 1'b1;
        tick();
        cu_if.start = 1'b0;
        tests = 0;
        edges = 0;
        while (tests < 3 && edges < 40) begin
            tick();
            edges++;
            if (outs() == 32'b000000100) tests++;
        end
        check("F0_third_test_seen", 32'(tests), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_reset_outs", outs(), O_ZERO);
        run(8'hF0, 1'b0, edges, shifts);
        check("F0_latency", 32'(edges), 32'd22);
        check("F0_done_outs", outs(), O_DONE1);
        check("F0_shifts", 32'(shifts), 32'd8);
        tick();

        // start held high through the run and in DONE: no retrigger.
        run(8'h0F, 1'b1, edges, shifts);
        check("hold_latency", 32'(edges), 32'd14);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_in_done", outs(), O_DONE1);
        end
        cu_if.start = 1'b0;
        tick();
        check("hold_release_idle", outs(), O_ZERO);
        tick();
        check("hold_stays_idle", outs(), O_ZERO);

        // Reset while in DONE, start still high.
        run(8'h00, 1'b1, edges, shifts);
        check("done_pre_reset", outs(), O_DONE0);
        rst = 1'b1;
        tick();
        check("done_reset_outs", outs(), O_ZERO);
        rst = 1'b0;
        cu_if.start = 1'b0;
        tick();
        check("post_reset_idle", outs(), O_ZERO);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
